// File: rtl/cpu1_mul_pkg.sv
// Shared types for the CPU1 multi-cycle multiply path: op codes, sequencer
// states, partial-product indices and their accumulation shifts.
package cpu1_mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULXUU = 2'd1,
        OP_MULXSU = 2'd2,
        OP_MULXSS = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CORR  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Bit 1 selects the src1 half, bit 0 selects the src2 half.
    typedef enum logic [1:0] {
        PP_LL = 2'd0,
        PP_LH = 2'd1,
        PP_HL = 2'd2,
        PP_HH = 2'd3
    } pp_idx_e;

    function automatic logic [5:0] pp_shift(input pp_idx_e idx);
        logic [5:0] sh;
        case (idx)
            PP_LL:   sh = 6'd0;
            PP_LH:   sh = 6'd16;
            PP_HL:   sh = 6'd16;
            default: sh = 6'd32;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/cpu1_mul16_pipe.sv
// Unsigned 16x16 multiplier with LATENCY output registers; the only DSP site.
// The pipe always advances so issued products drain while en is low.
module cpu1_mul16_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);

    logic [31:0] stage [LATENCY];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= 32'd0;
            end
        end else begin
            if (en) begin
                stage[0] <= 32'(a) * 32'(b);
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign p = stage[LATENCY-1];

endmodule

// File: rtl/cpu1_mul_sequencer.sv
// 32x32 multiply sequencer: issues up to four 16x16 partial products through a
// shared pipelined multiplier, accumulates them, then applies signed correction.
module cpu1_mul_sequencer
    import cpu1_mul_pkg::*;
#(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cancel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_src1,
    input  logic [31:0] in_src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result
);

    localparam logic [1:0] DRAIN_LAST = 2'(MUL_LATENCY - 1);

    // Handshake: a request transfers on a clock edge where in_valid & in_ready,
    // a result transfers where out_valid & out_ready; out_valid is ignored by the
    // consumer in any cycle with cancel=1.
    state_e      state;
    op_e         op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [1:0]  cnt;
    logic [63:0] acc;

    logic                   mul_en;
    logic [15:0]            mul_a;
    logic [15:0]            mul_b;
    logic [31:0]            mul_p;
    pp_idx_e                issue_idx;
    logic [MUL_LATENCY-1:0] tag_v;
    pp_idx_e                tag_idx [MUL_LATENCY];

    logic        last_issue;
    logic [63:0] addend;
    logic [63:0] acc_next;
    logic [63:0] corr;

    assign issue_idx  = pp_idx_e'(cnt);
    assign mul_en     = (state == ST_ISSUE) && !cancel && !reset;
    assign mul_a      = issue_idx[1] ? src1[31:16] : src1[15:0];
    assign mul_b      = issue_idx[0] ? src2[31:16] : src2[15:0];
    assign last_issue = (op == OP_MUL) ? (cnt == 2'd2) : (cnt == 2'd3);

    cpu1_mul16_pipe #(.LATENCY(MUL_LATENCY)) u_mul (
        .clk   (clk),
        .clear (reset | cancel),
        .en    (mul_en),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p)
    );

    // Index tags ride alongside the products so each lands at its own shift.
    always_ff @(posedge clk) begin
        if (reset || cancel) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= mul_en;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
            end
        end
        tag_idx[0] <= issue_idx;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_idx[i] <= tag_idx[i-1];
        end
    end

    always_comb begin
        addend   = {32'd0, mul_p} << pp_shift(tag_idx[MUL_LATENCY-1]);
        acc_next = tag_v[MUL_LATENCY-1] ? (acc + addend) : acc;
        corr     = 64'd0;
        if ((op == OP_MULXSU || op == OP_MULXSS) && src1[31]) begin
            corr = corr + {src2, 32'd0};
        end
        if (op == OP_MULXSS && src2[31]) begin
            corr = corr + {src1, 32'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            op    <= OP_MUL;
            src1  <= 32'd0;
            src2  <= 32'd0;
            cnt   <= 2'd0;
            acc   <= 64'd0;
        end else if (cancel) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op    <= op_e'(in_op);
                        src1  <= in_src1;
                        src2  <= in_src2;
                        acc   <= 64'd0;
                        cnt   <= 2'd0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    acc <= acc_next;
                    if (last_issue) begin
                        cnt   <= 2'd0;
                        state <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    acc <= acc_next;
                    if (cnt == DRAIN_LAST) begin
                        cnt   <= 2'd0;
                        state <= (op == OP_MUL) ? ST_DONE : ST_CORR;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                ST_CORR: begin
                    acc   <= acc - corr;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_result = acc;

endmodule

// File: tb/tb_cpu1_mul_sequencer.sv
// Directed bench for cpu1_mul_sequencer with MUL_LATENCY=1: results, latency,
// multiplier enable count, backpressure, cancel and mid-operation reset.
module tb_cpu1_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    int n_cmp = 0;
    int n_bad = 0;

    cpu1_mul_sequencer #(.MUL_LATENCY(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cancel     (cancel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation with out_ready=1; cycle 0 is the acceptance cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output int ens);
        int cyc;
        res = 64'd0;
        lat = -1;
        ens = 0;
        cyc = 0;
        in_op = op;
        in_src1 = a;
        in_src2 = b;
        in_valid = 1'b1;
        while (cyc < 40 && lat < 0) begin
            if (dut.mul_en) ens++;
            if (out_valid) begin
                lat = cyc;
                res = out_result;
            end
            step();
            in_valid = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 64'd0) begin n_bad++; $display("FAIL reset_out_result got %h want 0", out_result); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_mulxuu();
        logic [63:0] res;
        int lat, ens;
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ens);
        n_cmp++; if (res !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL mulxuu_result got %h want fffffffe00000001", res); end
        n_cmp++; if (lat != 7) begin n_bad++; $display("FAIL mulxuu_latency got %0d want 7", lat); end
        n_cmp++; if (ens != 4) begin n_bad++; $display("FAIL mulxuu_enables got %0d want 4", ens); end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat, ens;
        do_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ens);
        n_cmp++; if (res !== 64'hFFFF_FFFF_0000_0001) begin n_bad++; $display("FAIL mulxsu_neg got %h want ffffffff00000001", res); end
        do_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ens);
        n_cmp++; if (res !== 64'h0000_0000_0000_0001) begin n_bad++; $display("FAIL mulxss_neg got %h want 0000000000000001", res); end
        n_cmp++; if (lat != 7) begin n_bad++; $display("FAIL mulxss_latency got %0d want 7", lat); end
        do_op(2'd3, 32'h8000_0000, 32'h8000_0000, res, lat, ens);
        n_cmp++; if (res !== 64'h4000_0000_0000_0000) begin n_bad++; $display("FAIL mulxss_min got %h want 4000000000000000", res); end
        do_op(2'd2, 32'h0000_0002, 32'hFFFF_FFFF, res, lat, ens);
        n_cmp++; if (res !== 64'h0000_0001_FFFF_FFFE) begin n_bad++; $display("FAIL mulxsu_pos got %h want 00000001fffffffe", res); end
        do_op(2'd3, 32'h0000_0002, 32'hFFFF_FFFF, res, lat, ens);
        n_cmp++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulxss_mixed got %h want fffffffffffffffe", res); end
    endtask

    task automatic test_mul();
        logic [63:0] res;
        int lat, ens;
        do_op(2'd0, 32'h0001_2345, 32'h0001_0000, res, lat, ens);
        n_cmp++; if (res[31:0] !== 32'h2345_0000) begin n_bad++; $display("FAIL mul_result got %h want 23450000", res[31:0]); end
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL mul_latency got %0d want 5", lat); end
        n_cmp++; if (ens != 3) begin n_bad++; $display("FAIL mul_enables got %0d want 3", ens); end
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ens);
        n_cmp++; if (res[31:0] !== 32'h0000_0001) begin n_bad++; $display("FAIL mul_allones got %h want 00000001", res[31:0]); end
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        in_op = 2'd1;
        in_src1 = 32'h0001_0000;
        in_src2 = 32'h0001_0000;
        in_valid = 1'b1;
        cyc = 0;
        while (cyc < 40 && !out_valid) begin
            step();
            in_valid = 1'b0;
            cyc++;
            if (!out_valid) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_busy_in_ready cycle %0d got %b want 0", cyc, in_ready); end
            end
        end
        n_cmp++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL bp_timeout out_valid got 0 want 1 within 40 cycles");
        end else begin
            if (cyc != 7) begin n_bad++; $display("FAIL bp_latency got %0d want 7", cyc); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++; if (out_result !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL bp_result hold %0d got %h want 0000000100000000", k, out_result); end
                n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold %0d got valid=%b ready=%b want valid=1 ready=0", k, out_valid, in_ready); end
                if (k == 3) out_ready = 1'b1;
                step();
            end
            n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_cancel();
        logic [63:0] res;
        int lat, ens;
        in_op = 2'd3;
        in_src1 = 32'hFFFF_FFFF;
        in_src2 = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL cancel_idle got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || dut.mul_en !== 1'b0) begin n_bad++; $display("FAIL cancel_quiet got out_valid=%b mul_en=%b want 0/0", out_valid, dut.mul_en); end
        do_op(2'd0, 32'd3, 32'd5, res, lat, ens);
        n_cmp++; if (res[31:0] !== 32'h0000_000F) begin n_bad++; $display("FAIL cancel_next_mul got %h want 0000000f", res[31:0]); end
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL cancel_next_latency got %0d want 5", lat); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat, ens;
        in_op = 2'd1;
        in_src1 = 32'h1234_5678;
        in_src2 = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 64'd0) begin n_bad++; $display("FAIL rstmid_out_result got %h want 0", out_result); end
        do_op(2'd1, 32'd2, 32'd3, res, lat, ens);
        n_cmp++; if (res !== 64'h0000_0000_0000_0006) begin n_bad++; $display("FAIL rstmid_next got %h want 0000000000000006", res); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat, ens;
        do_op(2'd1, 32'h0000_FFFF, 32'h0001_0001, res, lat, ens);
        n_cmp++; if (res !== 64'h0000_0000_FFFF_FFFF) begin n_bad++; $display("FAIL b2b_first got %h want 00000000ffffffff", res); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap got in_ready=%b want 1", in_ready); end
        do_op(2'd1, 32'h0001_0000, 32'hFFFF_0000, res, lat, ens);
        n_cmp++; if (res !== 64'h0000_FFFF_0000_0000) begin n_bad++; $display("FAIL b2b_second got %h want 0000ffff00000000", res); end
    endtask

    initial begin
        reset = 1'b1;
        cancel = 1'b0;
        in_valid = 1'b0;
        in_op = 2'd0;
        in_src1 = 32'd0;
        in_src2 = 32'd0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_mulxuu();
        test_signed();
        test_mul();
        test_backpressure();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu1_mul_sequencer.md
Name: cpu1_mul_sequencer

Overview:
Multi-cycle multiply controller for the CPU1 custom/extended multiply path. It accepts one 32x32 multiply request at a time and time-shares a single pipelined 16x16 unsigned multiplier over up to four partial products. It accumulates the partial products into a 64-bit sum, applies the signed correction, and returns the result over a valid/ready handshake. It sits between the CPU1 issue stage and the writeback mux, and supports MUL (low 32), MULXUU, MULXSU and MULXSS (high word).

Parameters:
MUL_LATENCY, 1, pipeline depth in cycles of the 16x16 multiplier sub-module; legal values 1..3.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cancel  in  1  pipeline flush; aborts any operation in progress
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  2  0=MUL, 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS
in_src1  in  32  multiplicand
in_src2  in  32  multiplier
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  64  full product; for MUL only bits [31:0] are defined, [63:32] are don't-care

Behaviour:
- One clock domain: clk. reset is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, accumulator=0, issue count=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid & ~cancel, latch src1, src2 and op, clear the accumulator, go to ISSUE.
  - ISSUE: one partial product issued per cycle, in order LL (a[15:0]*b[15:0]), LH (a[15:0]*b[31:16]), HL (a[31:16]*b[15:0]), HH (a[31:16]*b[31:16]). MUL skips HH (3 issues); all other ops issue 4. After the last issue, go to DRAIN.
  - DRAIN: lasts MUL_LATENCY cycles while the remaining products return. Then go to CORR for ops 1-3, or to DONE for MUL.
  - CORR: one cycle. Subtract {src2,32'b0} if the src1 sign is honoured and src1[31]=1. Subtract {src1,32'b0} if the src2 sign is honoured and src2[31]=1. All arithmetic is modulo 2^64. Then go to DONE.
  - DONE: out_valid=1 and out_result held stable. On out_ready, go to IDLE.
- Accumulation: each returned product is added to the accumulator at its shift (LL<<0, LH<<16, HL<<16, HH<<32) in the cycle it emerges from the multiplier. Each product is tagged with its index, which travels down a MUL_LATENCY-deep shift register alongside it.
- Latency with MUL_LATENCY=1, counting the acceptance cycle as 0:
  - out_valid first high in cycle 5 for MUL.
  - out_valid first high in cycle 7 for ops 1-3.
  - General form: NPROD + MUL_LATENCY + (op!=0) + 1.
- Throughput: in_ready is high only in IDLE, so back-to-back operations always incur at least one idle cycle.
- cancel: has priority over everything except reset. In any state, the next state is IDLE, out_valid=0 from the next cycle, and in-flight product tags are invalidated. cancel in IDLE blocks acceptance. The consumer must ignore out_valid in any cycle where cancel=1.
- Reset mid-operation: same effect as cancel; outputs return to their reset values on the next edge.
- Backpressure: with out_valid=1 and out_ready=0, out_result must not change.
- The multiplier enable is high only while a product is issued. Inputs to the sub-module are don't-care otherwise.

Decomposition:
- Shared package cpu1_mul_pkg holds:
  - op enum MUL/MULXUU/MULXSU/MULXSS
  - state enum IDLE/ISSUE/DRAIN/CORR/DONE
  - partial-product index enum LL/LH/HL/HH
  - function giving the shift amount per index
- One sub-module, cpu1_mul16_pipe: unsigned 16x16 to 32-bit product with MUL_LATENCY registers, synchronous active-high clear, and an enable input. It is the only place the vendor DSP is inferred.

Test Plan:
- MULXUU, src1=0xFFFFFFFF, src2=0xFFFFFFFF, out_ready=1 -> out_result=0xFFFFFFFE_00000001, with out_valid rising in cycle 7 after acceptance.
- MULXSU, src1=0xFFFFFFFF, src2=0xFFFFFFFF -> 0xFFFFFFFF_00000001. MULXSS with the same operands -> 0x00000000_00000001. MULXSS, src1=0x80000000, src2=0x80000000 -> 0x40000000_00000000.
- MUL, src1=0x00012345, src2=0x00010000 -> out_result[31:0]=0x23450000, with out_valid in cycle 5 and the HH product never issued (multiplier enable high exactly 3 cycles).
- Backpressure: MULXUU 0x00010000*0x00010000, with out_ready held low for 3 cycles after out_valid -> result 0x00000001_00000000 stable, in_ready=0 throughout, IDLE one cycle after out_ready.
- cancel asserted in the second ISSUE cycle of a MULXSS -> out_valid stays 0. A new MUL 3*5 issued two cycles later -> 0x0000000F with no corruption from the aborted products.
- reset asserted in cycle 3 of a MULXUU -> next cycle in_ready=1, out_valid=0, out_result=0. A subsequent MULXUU 2*3 returns 0x00000000_00000006.
